// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg
// Types and constants shared by the instruction fetch unit files: FSM state
// encoding, FIFO entry layout, the instruction size and the default memory size.
// INSTR_MEM_SIZE is supplied by the memory build. It falls back to 128 bytes
// when the build does not define it.
`ifndef INSTR_MEM_SIZE
`define INSTR_MEM_SIZE 128
`endif

package instr_fetch_unit_pkg;

   localparam int INSTR_BYTES   = 4;
   localparam int IFU_MEM_BYTES = `INSTR_MEM_SIZE;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_HALT  = 2'd1,
      ST_TRAP  = 2'd2
   } ifu_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ifu_entry_t;

   function automatic logic word_aligned(input logic [31:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if
// Bundles the fetch unit's external signals into one interface.
//   InstrAddr / Instr          : instruction memory address and returned word
//   redir_valid / redir_pc     : control-flow redirect from execute
//   dec_valid / dec_ready      : handshake toward decode
//   dec_instr / dec_pc         : head instruction and its PC
//   halted / fault             : fetch status
// Modport master is the fetch unit. Modport slave is the surrounding memory,
// execute and decode.
interface instr_fetch_unit_if;
   logic [31:0] InstrAddr;
   logic [31:0] Instr;
   logic        redir_valid;
   logic [31:0] redir_pc;
   logic        dec_valid;
   logic        dec_ready;
   logic [31:0] dec_instr;
   logic [31:0] dec_pc;
   logic        halted;
   logic        fault;

   modport master (
      output InstrAddr, dec_valid, dec_instr, dec_pc, halted, fault,
      input  Instr, redir_valid, redir_pc, dec_ready
   );

   modport slave (
      input  InstrAddr, dec_valid, dec_instr, dec_pc, halted, fault,
      output Instr, redir_valid, redir_pc, dec_ready
   );
endinterface

// File: rtl/instr_fetch_unit_ifu_fifo.sv
// ifu_fifo
// A synchronous FIFO that holds {pc, instr} entries.
//   clk, rst     : clock and asynchronous active-high reset
//   push/wr_data : write an entry at the tail
//   pop          : advance the head
//   flush        : empty the FIFO; it overrides push and pop
//   rd_data      : head entry, driven combinationally
//   count, full  : current occupancy
// DEPTH must be a power of two so that the pointers wrap without any extra logic.
module ifu_fifo
   import instr_fetch_unit_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  ifu_entry_t             wr_data,
   output ifu_entry_t             rd_data,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   ifu_entry_t      mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;

   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign rd_data = mem[rd_ptr];
   assign full    = (count == CW'(DEPTH));

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// The fetch-side initiator. It owns the PC, drives the instruction memory
// address, buffers the returned words with their PCs, and presents them to
// decode over a valid/ready handshake. It takes redirects from execute and
// halts when the PC leaves the memory range.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : instr_fetch_unit_if.master (memory, redirect, decode, status)
// Optional feature: when IFU_MISALIGN_TRAP_EN is defined, a misaligned redirect
// traps and raises fault. When it is not defined, the redirect target is
// force-aligned and fault is tied to 0.
//
// state    | meaning
// ---------+------------------------------------------------------
// ST_FETCH | pc in range; one word pushed per cycle when FIFO has room
// ST_HALT  | pc >= MEM_BYTES; waits for an in-range redirect
// ST_TRAP  | misaligned redirect caught (trap build only); fault = 1
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'd0,
   parameter int          MEM_BYTES  = IFU_MEM_BYTES,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   instr_fetch_unit_if.master bus
);

   localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

   ifu_state_t                  state;
   logic [31:0]                 pc;
   logic [31:0]                 pc_inc;
   logic [31:0]                 redir_tgt;
   logic                        push;
   logic                        pop;
   logic                        fifo_full;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   ifu_entry_t                  head;
   ifu_entry_t                  wr_entry;

   assign pc_inc   = pc + 32'(INSTR_BYTES);
   assign pop      = bus.dec_valid && bus.dec_ready;
   assign push     = (state == ST_FETCH) && !bus.redir_valid && (!fifo_full || pop);
   assign wr_entry = '{pc: pc, instr: bus.Instr};

`ifdef IFU_MISALIGN_TRAP_EN
   logic fault_q;
   assign redir_tgt = bus.redir_pc;
`else
   assign redir_tgt = bus.redir_pc & ~32'h3;
`endif

   // The state is computed from the value pc is about to take. That way halted
   // rises on the same edge that carries pc out of range, and no word is ever
   // pushed from an out-of-range address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_FETCH;
         pc      <= RESET_PC;
`ifdef IFU_MISALIGN_TRAP_EN
         fault_q <= 1'b0;
`endif
      end else if (bus.redir_valid) begin
         pc <= redir_tgt;
`ifdef IFU_MISALIGN_TRAP_EN
         if (!word_aligned(redir_tgt)) begin
            state   <= ST_TRAP;
            fault_q <= 1'b1;
         end else begin
            state   <= (redir_tgt >= MEM_LIMIT) ? ST_HALT : ST_FETCH;
            fault_q <= 1'b0;
         end
`else
         state <= (redir_tgt >= MEM_LIMIT) ? ST_HALT : ST_FETCH;
`endif
      end else if (push) begin
         pc    <= pc_inc;
         state <= (pc_inc >= MEM_LIMIT) ? ST_HALT : ST_FETCH;
      end
   end

   ifu_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .pop     (pop),
      .flush   (bus.redir_valid),
      .wr_data (wr_entry),
      .rd_data (head),
      .count   (fifo_count),
      .full    (fifo_full)
   );

   assign bus.InstrAddr = pc;
   assign bus.dec_valid = (fifo_count != '0);
   // Gate the head to zero when the FIFO is empty, so that stale storage never
   // reaches decode. This also gives zero outputs out of reset without clearing
   // the storage array.
   assign bus.dec_instr = bus.dec_valid ? head.instr : 32'd0;
   assign bus.dec_pc    = bus.dec_valid ? head.pc    : 32'd0;
   assign bus.halted    = (state == ST_HALT);
`ifdef IFU_MISALIGN_TRAP_EN
   assign bus.fault     = fault_q;
`else
   assign bus.fault     = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit
// Directed bench for instr_fetch_unit. It uses a 128-byte big-endian memory
// model in which the word at address a is 32'hA500_0000 | a.
module tb_instr_fetch_unit;

   logic clk;
   logic rst;
   logic [7:0] mem [128];
   int checks;
   int errors;

   instr_fetch_unit_if bus ();

   instr_fetch_unit #(
      .RESET_PC   (32'd0),
      .MEM_BYTES  (128),
      .FIFO_DEPTH (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] wexp(input logic [31:0] a);
      return 32'hA500_0000 | a;
   endfunction

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      logic [6:0] i;
      i = a[6:0];
      if (a >= 32'd128) return 32'd0;
      return {mem[i], mem[i + 7'd1], mem[i + 7'd2], mem[i + 7'd3]};
   endfunction

   assign bus.Instr = mem_rd(bus.InstrAddr);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic rdy);
      rst = 1'b1;
      bus.redir_valid = 1'b0;
      bus.redir_pc = 32'd0;
      bus.dec_ready = rdy;
      step();
      rst = 1'b0;
   endtask

   task automatic redirect(input logic [31:0] tgt);
      bus.redir_valid = 1'b1;
      bus.redir_pc = tgt;
      step();
      bus.redir_valid = 1'b0;
   endtask

   initial begin
      logic [31:0] w;
      checks = 0;
      errors = 0;
      for (int a = 0; a < 128; a += 4) begin
         w = 32'hA500_0000 | 32'(a);
         mem[a]   = w[31:24];
         mem[a+1] = w[23:16];
         mem[a+2] = w[15:8];
         mem[a+3] = w[7:0];
      end

      // Reset values, observed before any clock edge.
      rst = 1'b1;
      bus.redir_valid = 1'b0;
      bus.redir_pc = 32'd0;
      bus.dec_ready = 1'b1;
      #1;
      chk("rst_valid",  32'(bus.dec_valid), 32'd0);
      chk("rst_instr",  bus.dec_instr, 32'd0);
      chk("rst_pc",     bus.dec_pc, 32'd0);
      chk("rst_addr",   bus.InstrAddr, 32'd0);
      chk("rst_halted", 32'(bus.halted), 32'd0);
      chk("rst_fault",  32'(bus.fault), 32'd0);

      // Streaming delivery at one instruction per cycle.
      do_reset(1'b1);
      chk("first_pre", 32'(bus.dec_valid), 32'd0);
      step();
      for (int i = 0; i < 4; i++) begin
         chk("stream_valid", 32'(bus.dec_valid), 32'd1);
         chk("stream_pc",    bus.dec_pc, 32'(4*i));
         chk("stream_instr", bus.dec_instr, wexp(32'(4*i)));
         step();
      end

      // Backpressure: the FIFO saturates at 2 entries and the pc holds at 8.
      do_reset(1'b0);
      for (int i = 0; i < 5; i++) step();
      chk("bp_addr",  bus.InstrAddr, 32'h8);
      chk("bp_valid", 32'(bus.dec_valid), 32'd1);
      bus.dec_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("bp_pc",    bus.dec_pc, 32'(4*i));
         chk("bp_instr", bus.dec_instr, wexp(32'(4*i)));
         step();
      end

      // Redirect while the FIFO holds 2 entries.
      do_reset(1'b0);
      step(); step();
      chk("rd_full_valid", 32'(bus.dec_valid), 32'd1);
      redirect(32'h40);
      chk("rd_flush_valid", 32'(bus.dec_valid), 32'd0);
      chk("rd_addr", bus.InstrAddr, 32'h40);
      bus.dec_ready = 1'b1;
      step();
      chk("rd_new_valid", 32'(bus.dec_valid), 32'd1);
      chk("rd_new_pc",    bus.dec_pc, 32'h40);
      chk("rd_new_instr", bus.dec_instr, wexp(32'h40));

      // Run off the end of memory, then redirect back into range.
      redirect(32'h70);
      step(); step(); step();
      chk("end_pre_halt", 32'(bus.halted), 32'd0);
      step();
      chk("end_addr",   bus.InstrAddr, 32'h80);
      chk("end_halted", 32'(bus.halted), 32'd1);
      chk("end_last",   bus.dec_pc, 32'h7C);
      step();
      chk("end_nopush", 32'(bus.dec_valid), 32'd0);
      chk("end_hold",   bus.InstrAddr, 32'h80);
      redirect(32'h10);
      chk("res_halted", 32'(bus.halted), 32'd0);
      step();
      chk("res_pc",    bus.dec_pc, 32'h10);
      chk("res_instr", bus.dec_instr, wexp(32'h10));

      // Misaligned redirect.
      redirect(32'h22);
`ifdef IFU_MISALIGN_TRAP_EN
      chk("mis_fault", 32'(bus.fault), 32'd1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("mis_trap_valid", 32'(bus.dec_valid), 32'd0);
         chk("mis_trap_fault", 32'(bus.fault), 32'd1);
      end
      redirect(32'h24);
      chk("mis_clear", 32'(bus.fault), 32'd0);
      step();
      chk("mis_pc", bus.dec_pc, 32'h24);
      chk("mis_instr", bus.dec_instr, wexp(32'h24));
`else
      chk("mis_addr", bus.InstrAddr, 32'h20);
      step();
      chk("mis_pc",    bus.dec_pc, 32'h20);
      chk("mis_instr", bus.dec_instr, wexp(32'h20));
      chk("mis_fault", 32'(bus.fault), 32'd0);
`endif

      // Asynchronous reset with the FIFO full.
      bus.dec_ready = 1'b0;
      redirect(32'h30);
      step(); step(); step();
      chk("ar_pre_valid", 32'(bus.dec_valid), 32'd1);
      chk("ar_pre_addr",  bus.InstrAddr, 32'h38);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_valid", 32'(bus.dec_valid), 32'd0);
      chk("ar_instr", bus.dec_instr, 32'd0);
      chk("ar_pc",    bus.dec_pc, 32'd0);
      chk("ar_addr",  bus.InstrAddr, 32'd0);
      chk("ar_halt",  32'(bus.halted), 32'd0);
      chk("ar_fault", 32'(bus.fault), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
